// File: rtl/cmd_uart_wrapper.sv
// Command-link UART endpoint: assembles two-byte commands from RX frames and
// serializes a one-byte response on TX. 8N1 framing, LSB first.
`timescale 1ns/1ps
module cmd_uart_wrapper #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    logic            rx_p0, rx_p1, rx_p2;
    logic [1:0]      rx_warm;
    logic            rx_armed;
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [3:0]      rx_bits, rx_bits_nxt;
    logic            rx_shift, rx_ok, rx_bad;
    logic            rx_byte_rdy, rx_frame_err;
    logic [7:0]      rx_data;
    logic [7:0]      cmd_hi;
    logic            byte_idx;

    tx_state_t       tx_state, tx_state_nxt;
    logic [CW-1:0]   tx_cnt, tx_cnt_nxt;
    logic [3:0]      tx_bits, tx_bits_nxt;
    logic            tx_load, tx_shift, tx_done;
    logic [9:0]      tx_sh;

    // Synchronizer; the armed flag ignores edges until the line has been seen
    // idle after reset, so a reset mid-frame cannot fabricate a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_p0    <= 1'b1;
            rx_p1    <= 1'b1;
            rx_p2    <= 1'b1;
            rx_warm  <= 2'b00;
            rx_armed <= 1'b0;
        end else begin
            rx_p0   <= RX;
            rx_p1   <= rx_p0;
            rx_p2   <= rx_p1;
            rx_warm <= {rx_warm[0], 1'b1};
            if (rx_warm[1] && rx_p1)
                rx_armed <= 1'b1;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bits_nxt  = rx_bits;
        rx_shift     = 1'b0;
        rx_ok        = 1'b0;
        rx_bad       = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_armed && rx_p2 && !rx_p1) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_p1) begin
                        rx_state_nxt = RX_DATA;
                        rx_cnt_nxt   = BIT_LOAD;
                        rx_bits_nxt  = 4'd0;
                    end else begin
                        rx_state_nxt = RX_IDLE;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift   = 1'b1;
                    rx_cnt_nxt = BIT_LOAD;
                    if (rx_bits == 4'd7)
                        rx_state_nxt = RX_STOP;
                    else
                        rx_bits_nxt = rx_bits + 4'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_nxt = RX_IDLE;
                    rx_ok        = rx_p1;
                    rx_bad       = !rx_p1;
                end else begin
                    rx_cnt_nxt = rx_cnt - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bits      <= 4'd0;
            rx_byte_rdy  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_state     <= rx_state_nxt;
            rx_cnt       <= rx_cnt_nxt;
            rx_bits      <= rx_bits_nxt;
            rx_byte_rdy  <= rx_ok;
            rx_frame_err <= rx_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_shift)
            rx_data <= {rx_p1, rx_data[7:1]};
        if (rx_byte_rdy && !byte_idx)
            cmd_hi <= rx_data;
    end

    // Command assembly: a completing second byte takes priority over clr_cmd_rdy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd      <= 16'h0000;
            cmd_rdy  <= 1'b0;
            byte_idx <= 1'b0;
        end else if (rx_byte_rdy) begin
            if (!byte_idx) begin
                byte_idx <= 1'b1;
                cmd_rdy  <= 1'b0;
            end else begin
                cmd      <= {cmd_hi, rx_data};
                cmd_rdy  <= 1'b1;
                byte_idx <= 1'b0;
            end
        end else begin
            if (rx_frame_err)
                byte_idx <= 1'b0;
            if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bits_nxt  = tx_bits;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;
        tx_done      = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_state_nxt = TX_XMIT;
                    tx_load      = 1'b1;
                    tx_cnt_nxt   = BIT_LOAD;
                    tx_bits_nxt  = 4'd0;
                end
            end
            TX_XMIT: begin
                if (tx_cnt == '0) begin
                    if (tx_bits == 4'd9) begin
                        tx_state_nxt = TX_IDLE;
                        tx_done      = 1'b1;
                    end else begin
                        tx_shift    = 1'b1;
                        tx_bits_nxt = tx_bits + 4'd1;
                        tx_cnt_nxt  = BIT_LOAD;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bits   <= 4'd0;
            resp_sent <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bits   <= tx_bits_nxt;
            resp_sent <= tx_done;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_load)
            tx_sh <= {1'b1, resp, 1'b0};
        else if (tx_shift)
            tx_sh <= {1'b1, tx_sh[9:1]};
    end

    assign TX      = (tx_state == TX_XMIT) ? tx_sh[0] : 1'b1;
    assign tx_busy = (tx_state == TX_XMIT);

endmodule
